// File: rtl/r_fifo.sv
// Four-line scaling line buffer: rows written per one-hot select, read back
// concurrently at a horizontally scaled, clamped source address.
module r_fifo (
  input  logic        clk,
  input  logic        rstn,
  input  logic        b_clk,
  input  logic        b_rst,
  input  logic [9:0]  x_scale,
  input  logic [3:0]  ram_select,
  input  logic [10:0] wr_addr,
  input  logic [15:0] wr_data,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [10:0] x_pos,
  output logic [15:0] x1_data,
  output logic [15:0] x2_data,
  output logic [15:0] x3_data,
  output logic [15:0] x4_data
);

  logic [20:0] prod;
  logic [12:0] src;
  logic [10:0] raddr;
  logic        rd_rst_n;

  // Either reset input clears the read side; they are the same net in practice.
  assign rd_rst_n = rstn & b_rst;

  assign prod = 21'(x_pos) * 21'(x_scale);
  assign src  = 13'(prod >> 8);

  // Address 0 is not a valid pixel, so the left edge replicates pixel 1.
  always_comb begin
    raddr = src[10:0];
    if (src == 13'd0) begin
      raddr = 11'd1;
    end else if (src > 13'd2047) begin
      raddr = 11'd2047;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_buf
      logic [15:0] mem [2048];
      logic [15:0] rdata_q;

      always_ff @(posedge clk) begin
        if (wr_en && ram_select[gi]) begin
          mem[wr_addr] <= wr_data;
        end
      end

      // Read port sits on the read-side clock; same-edge writes are read-first.
      always_ff @(posedge b_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
          rdata_q <= '0;
        end else if (rd_en) begin
          rdata_q <= mem[raddr];
        end
      end
    end
  endgenerate

  assign x1_data = g_buf[0].rdata_q;
  assign x2_data = g_buf[1].rdata_q;
  assign x3_data = g_buf[2].rdata_q;
  assign x4_data = g_buf[3].rdata_q;

endmodule

// File: tb/tb_r_fifo.sv
// Directed bench for r_fifo: stimulus pushes expected read data into a
// scoreboard queue; a negedge monitor pops and compares each returned read.
module tb_r_fifo;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [9:0]  x_scale = '0;
  logic [3:0]  ram_select = '0;
  logic [10:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [10:0] x_pos = '0;
  logic [15:0] x1_data, x2_data, x3_data, x4_data;
  logic [3:0][15:0] dout;
  logic        done = 1'b0;

  r_fifo dut (
    .clk(clk), .rstn(rstn), .b_clk(clk), .b_rst(rstn),
    .x_scale(x_scale), .ram_select(ram_select), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_en(wr_en), .rd_en(rd_en), .x_pos(x_pos),
    .x1_data(x1_data), .x2_data(x2_data), .x3_data(x3_data), .x4_data(x4_data)
  );

  assign dout = {x4_data, x3_data, x2_data, x1_data};

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][15:0] d;
    logic [3:0]       m;
    string            name;
  } exp_t;

  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;
  logic rd_seen;
  logic [3:0][15:0] hold_d;
  logic [3:0] hold_m;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) rd_seen <= 1'b0;
    else       rd_seen <= rd_en;
  end

  // Monitor: reset zeros, scoreboard pops on returned reads, hold otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end else if (!rstn) begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (dout[k] !== 16'h0000) begin
          errors++;
          $display("FAIL reset x%0d_data: got %h expected 0000", k + 1, dout[k]);
        end
      end
      hold_d <= '0;
      hold_m <= 4'hF;
    end else if (rd_seen) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow: read returned with no expectation");
      end else begin
        e = exp_q.pop_front();
        for (int k = 0; k < 4; k++) begin
          if (e.m[k]) begin
            checks++;
            if (dout[k] !== e.d[k]) begin
              errors++;
              $display("FAIL %s x%0d_data: got %h expected %h", e.name, k + 1, dout[k], e.d[k]);
            end
          end
        end
        $display("read %s: x1=%h x2=%h x3=%h x4=%h", e.name, x1_data, x2_data, x3_data, x4_data);
        hold_d <= e.d;
        hold_m <= e.m;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (hold_m[k]) begin
          checks++;
          if (dout[k] !== hold_d[k]) begin
            errors++;
            $display("FAIL hold x%0d_data: got %h expected %h", k + 1, dout[k], hold_d[k]);
          end
        end
      end
    end
  end

  task automatic wr(input logic [3:0] sel, input logic [10:0] a, input logic [15:0] d);
    @(negedge clk);
    ram_select = sel; wr_addr = a; wr_data = d; wr_en = 1'b1; rd_en = 1'b0;
  endtask

  task automatic rd(input logic [9:0] sc, input logic [10:0] xp,
                    input logic [15:0] e1, input logic [15:0] e2,
                    input logic [15:0] e3, input logic [15:0] e4,
                    input logic [3:0] m, input string nm);
    exp_t e;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b1; x_scale = sc; x_pos = xp;
    e.d = {e4, e3, e2, e1}; e.m = m; e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      wr_en = 1'b0; rd_en = 1'b0;
    end
  endtask

  initial begin
    exp_t e;
    #12;
    @(negedge clk);
    rstn = 1'b1;
    idle(3);

    for (int n = 1; n <= 640; n++) wr(4'b0001, 11'(n), 16'(n));
    for (int n = 1; n <= 640; n++) wr(4'b0010, 11'(n), 16'(n + 1000));
    idle(2);

    rd(10'd384, 11'd2,   16'd3,   16'd1003, 16'd0, 16'd0, 4'b0011, "rotate_x2");
    rd(10'd384, 11'd0,   16'd1,   16'd1001, 16'd0, 16'd0, 4'b0011, "scale_x0");
    rd(10'd384, 11'd1,   16'd1,   16'd1001, 16'd0, 16'd0, 4'b0011, "scale_x1");
    rd(10'd384, 11'd2,   16'd3,   16'd1003, 16'd0, 16'd0, 4'b0011, "scale_x2");
    rd(10'd384, 11'd3,   16'd4,   16'd1004, 16'd0, 16'd0, 4'b0011, "scale_x3");
    rd(10'd384, 11'd427, 16'd640, 16'd1640, 16'd0, 16'd0, 4'b0011, "scale_x427");
    idle(5);

    // Same-edge write and read of buffer0 address 5: old data returns first.
    @(negedge clk);
    ram_select = 4'b0001; wr_addr = 11'd5; wr_data = 16'd99; wr_en = 1'b1;
    rd_en = 1'b1; x_scale = 10'd256; x_pos = 11'd5;
    e.d = {16'd0, 16'd0, 16'd1005, 16'd5}; e.m = 4'b0011; e.name = "collide_old";
    exp_q.push_back(e);
    rd(10'd256, 11'd5, 16'd99, 16'd1005, 16'd0, 16'd0, 4'b0011, "collide_new");
    idle(2);

    wr(4'b1111, 11'd2047, 16'hA5A5);
    wr(4'b1100, 11'd1,    16'h0C0C);
    wr(4'b0000, 11'd1,    16'hDEAD);
    wr(4'b0000, 11'd2047, 16'hDEAD);
    rd(10'd1023, 11'd2047, 16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5, 4'b1111, "sat_high");
    rd(10'd1023, 11'd0,    16'd1, 16'd1001, 16'h0C0C, 16'h0C0C, 4'b1111, "sat_low");
    rd(10'd256,  11'd2047, 16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5, 4'b1111, "edge_2047");
    rd(10'd1,    11'd255,  16'd1, 16'd1001, 16'h0C0C, 16'h0C0C, 4'b1111, "frac_zero");
    rd(10'd1023, 11'd1,    16'd3, 16'd1003, 16'd0, 16'd0, 4'b0011, "scale_max_x1");
    rd(10'd2,    11'd1024, 16'd8, 16'd1008, 16'd0, 16'd0, 4'b0011, "scale_small");
    idle(3);

    // Reset lands between edges with a read strobe pending; no read returns.
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b1; x_scale = 10'd1023; x_pos = 11'd2047;
    #2 rstn = 1'b0;
    @(negedge clk);
    rd_en = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    idle(3);
    rd(10'd256, 11'd640, 16'd640, 16'd1640, 16'd0, 16'd0, 4'b0011, "after_reset");
    idle(2);
    done = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
